result_select_reg: RTL

Registered, parametrised successor to the lab's sum/carry output selector. Captures an adder result (WIDTH-bit sum plus carry-out) with a valid strobe and drives a registered WIDTH-bit display word: either the sum or the carry-out zero-extended into bit 0. Supports manual selection and an automatic mode that alternates between the two at a programmable dwell interval. Sits between the adder datapath and the LED/seven-segment output logic.

---
 rtl/result_select_reg.sv | 99 +++++++++
 1 files changed

// File: rtl/result_select_reg.sv
// rtl/result_select_reg.sv - registered sum/carry display selector with manual and auto-alternate views
module result_select_reg #(
    parameter int WIDTH = 4,
    parameter int DWELL = 50_000_000,
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    input  logic             in_valid,
    input  logic             sel,
    input  logic             mode,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    output logic             showing_sum
);

    typedef enum logic {
        SHOW_CARRY = 1'b0,
        SHOW_SUM   = 1'b1
    } view_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             o_valid_q, o_valid_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    view_t            state_q, state_d;

    logic [WIDTH-1:0] d_s;
    logic             d_c;

    always_comb begin
        s_d       = s_q;
        cout_d    = cout_q;
        o_valid_d = o_valid_q;
        if (in_valid) begin
            s_d       = s;
            cout_d    = cout;
            o_valid_d = 1'b1;
        end
        // Fresh data bypasses the capture register so o updates with 1-cycle latency.
        d_s    = in_valid ? s : s_q;
        d_c    = in_valid ? cout : cout_q;
        mode_d = mode;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (!mode || !mode_q) begin
            // Manual mode, or first auto cycle: start from sel with a fresh dwell.
            state_d = sel ? SHOW_SUM : SHOW_CARRY;
            cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
            state_d = (state_q == SHOW_SUM) ? SHOW_CARRY : SHOW_SUM;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        o_d    = '0;
        o_d[0] = d_c;
        if (state_d == SHOW_SUM) begin
            o_d = d_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= '0;
            cout_q    <= 1'b0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= SHOW_CARRY;
        end else begin
            s_q       <= s_d;
            cout_q    <= cout_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
        end
    end

    assign o           = o_q;
    assign o_valid     = o_valid_q;
    assign showing_sum = (state_q == SHOW_SUM);

endmodule
